fetch_stage: RTL and testbench

//  Instruction-fetch front end for the multi-cycle LoongArch core; sits upstream of decode.

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_stage.sv | 88 ++++++++
 tb/tb_fetch_stage.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch front end: state encodings,
// reset PC default, fetch-to-decode bus width and the next-PC rule.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,
        F_WAIT = 2'd1,
        F_HOLD = 2'd2,
        F_IDLE = 2'd3
    } fs_state_e;

    localparam logic [31:0] RESET_PC_DEF    = 32'h1c00_0000;
    localparam int          FS_TO_DS_BUS_WD = 64;

    // Redirect targets are word-aligned by clearing the low two bits; pc+4 wraps mod 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                            input logic        taken,
                                            input logic [31:0] target);
        return taken ? (target & 32'hFFFF_FFFC) : pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, reads one instruction from the
// inst SRAM, hands {pc, inst} to decode and waits for the next-PC decision.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          SRAM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    input  logic        ds_allowin,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_target
);

    localparam logic [2:0] WAIT_INIT = 3'(SRAM_LAT - 1);

    fs_state_e                  state;
    fs_state_e                  state_nxt;
    logic [31:0]                pc;
    logic [31:0]                inst_q;
    logic [2:0]                 wait_cnt;
    logic                       capture;
    logic                       pc_update;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= F_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            F_REQ:   state_nxt = F_WAIT;
            F_WAIT:  if (wait_cnt == 3'd0) state_nxt = F_HOLD;
            F_HOLD:  if (ds_allowin) state_nxt = F_IDLE;
            F_IDLE:  if (resolve_valid) state_nxt = F_REQ;
            default: state_nxt = F_REQ;
        endcase
    end

    always_comb begin
        fs_to_ds_valid  = (state == F_HOLD);
        capture         = (state == F_WAIT) && (wait_cnt == 3'd0);
        pc_update       = (state == F_IDLE) && resolve_valid;
        inst_sram_we    = 1'b0;
        inst_sram_wdata = 32'd0;
        inst_sram_addr  = pc;
    end

    // Reset also clears pc/inst so an in-flight read is discarded, never delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            inst_q   <= 32'd0;
            wait_cnt <= 3'd0;
        end else begin
            if (state == F_REQ) begin
                wait_cnt <= WAIT_INIT;
            end else if ((state == F_WAIT) && (wait_cnt != 3'd0)) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            if (capture) begin
                inst_q <= inst_sram_rdata;
            end
            if (pc_update) begin
                pc <= next_pc(pc, resolve_taken, resolve_target);
            end
        end
    end

    assign fs_to_ds_bus = {pc, inst_q};
    assign fs_pc        = fs_to_ds_bus[63:32];
    assign fs_inst      = fs_to_ds_bus[31:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: two instances (SRAM_LAT=1 and 3), each with
// an SRAM model, a directed+random driver, and a decoupled output monitor.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    logic clk = 1'b0;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int lanes_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents; epoch changes on selected resets so stale reads are distinguishable.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input int unsigned ep);
        if (a == RST_PC && ep == 0) return 32'h0280_0421;
        return (a * 32'h9E37_79B9) ^ (ep * 32'h0101_0101) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (cycle %0d): got %08h expected %08h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        reset = 1'b1;
        logic        ds_allowin = 1'b0;
        logic        resolve_valid = 1'b0;
        logic        resolve_taken = 1'b0;
        logic [31:0] resolve_target = 32'd0;
        logic [31:0] inst_sram_rdata;
        logic        inst_sram_we;
        logic        fs_to_ds_valid;
        logic [31:0] inst_sram_addr;
        logic [31:0] inst_sram_wdata;
        logic [31:0] fs_pc;
        logic [31:0] fs_inst;

        int unsigned epoch = 0;
        logic [31:0] data_hist [LAT];
        logic [63:0] exp_q [$];
        logic [31:0] exp_addr = RST_PC;
        bit          pend = 1'b0;
        int          req_cyc = 0;
        int          hs_cnt = 0;

        fetch_stage #(.RESET_PC(RST_PC), .SRAM_LAT(LAT)) dut (
            .clk             (clk),
            .reset           (reset),
            .inst_sram_we    (inst_sram_we),
            .inst_sram_addr  (inst_sram_addr),
            .inst_sram_wdata (inst_sram_wdata),
            .inst_sram_rdata (inst_sram_rdata),
            .fs_to_ds_valid  (fs_to_ds_valid),
            .fs_pc           (fs_pc),
            .fs_inst         (fs_inst),
            .ds_allowin      (ds_allowin),
            .resolve_valid   (resolve_valid),
            .resolve_taken   (resolve_taken),
            .resolve_target  (resolve_target)
        );

        // SRAM: data for the address seen in cycle n appears on rdata in cycle n+LAT.
        always @(posedge clk) begin
            data_hist[0] <= mem_word(inst_sram_addr, epoch);
            for (int i = 1; i < LAT; i++) data_hist[i] <= data_hist[i - 1];
        end
        assign inst_sram_rdata = data_hist[LAT - 1];

        task automatic issue(input logic [31:0] pc);
            exp_addr = pc;
            exp_q.push_back({pc, mem_word(pc, epoch)});
            pend = 1'b1;
            req_cyc = cyc;
        endtask

        task automatic do_reset(input int n, input bit bump);
            reset = 1'b1;
            ds_allowin = 1'b0;
            resolve_valid = 1'b0;
            if (bump) epoch++;
            exp_q.delete();
            pend = 1'b0;
            repeat (n) tick();
            chk("rst_valid", {31'd0, fs_to_ds_valid}, 32'd0);
            chk("rst_addr", inst_sram_addr, RST_PC);
            chk("rst_inst", fs_inst, 32'd0);
            reset = 1'b0;
            issue(RST_PC);
        endtask

        // Drive decode until the current instruction is accepted.
        task automatic deliver(input int stall, input bit rand_allow, input bit spur);
            int start;
            start = hs_cnt;
            for (int k = 0; k < 100; k++) begin
                ds_allowin = (k >= stall) && (!rand_allow || $urandom_range(0, 2) != 0);
                resolve_valid = spur && (k % 2 == 0);
                resolve_taken = 1'($urandom_range(0, 1));
                resolve_target = $urandom;
                tick();
                resolve_valid = 1'b0;
                ds_allowin = 1'($urandom_range(0, 1));
                if (hs_cnt != start) return;
            end
            checks++;
            failures++;
            $display("FAIL handshake_timeout (cycle %0d): hs_cnt %0d required %0d", cyc, hs_cnt, start + 1);
        endtask

        // Report the next-PC decision while fetch is idle, then start the next fetch.
        task automatic redirect(input int gap, input bit taken, input logic [31:0] tgt);
            logic [31:0] npc;
            repeat (gap) begin
                ds_allowin = 1'($urandom_range(0, 1));
                tick();
            end
            resolve_valid = 1'b1;
            resolve_taken = taken;
            resolve_target = tgt;
            npc = taken ? (tgt & 32'hFFFF_FFFC) : exp_addr + 32'd4;
            tick();
            resolve_valid = 1'b0;
            issue(npc);
        endtask

        initial begin : monitor
            bit exp_v;
            forever begin
                @(negedge clk);
                if (reset !== 1'b0) continue;
                chk("addr", inst_sram_addr, exp_addr);
                chk("we_wdata", {31'd0, inst_sram_we} | inst_sram_wdata, 32'd0);
                exp_v = pend && (cyc >= req_cyc + LAT + 1);
                chk("valid", {31'd0, fs_to_ds_valid}, {31'd0, exp_v});
                if (fs_to_ds_valid && exp_v && exp_q.size() != 0) begin
                    chk("fs_pc", fs_pc, exp_q[0][63:32]);
                    chk("fs_inst", fs_inst, exp_q[0][31:0]);
                    if (ds_allowin) begin
                        void'(exp_q.pop_front());
                        pend = 1'b0;
                        hs_cnt++;
                    end
                end
            end
        end

        initial begin : driver
            do_reset(2, 1'b0);
            if (LAT == 1) begin
                deliver(7, 1'b0, 1'b0);
                redirect(0, 1'b0, 32'h0);
                chk("seq_addr", inst_sram_addr, 32'h1c00_0004);
                deliver(0, 1'b0, 1'b0);
                redirect(2, 1'b1, 32'h1c00_0100);
                chk("taken_addr", inst_sram_addr, 32'h1c00_0100);
                deliver(0, 1'b0, 1'b1);
                redirect(1, 1'b1, 32'h1c00_0102);
                chk("align_addr", inst_sram_addr, 32'h1c00_0100);
                deliver(4, 1'b0, 1'b1);
                redirect(0, 1'b0, 32'h0);
                chk("hold_pulse_addr", inst_sram_addr, 32'h1c00_0104);
                tick();
                do_reset(1, 1'b1);
                deliver(0, 1'b0, 1'b0);
            end else begin
                deliver(0, 1'b0, 1'b0);
                redirect(0, 1'b1, 32'hFFFF_FFFF);
                chk("top_addr", inst_sram_addr, 32'hFFFF_FFFC);
                deliver(2, 1'b0, 1'b0);
                redirect(1, 1'b0, 32'h0);
                chk("wrap_addr", inst_sram_addr, 32'h0000_0000);
                deliver(0, 1'b0, 1'b0);
            end
            for (int n = 0; n < 30; n++) begin
                redirect($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom);
                deliver($urandom_range(0, 4), 1'b1, 1'($urandom_range(0, 1)));
            end
            lanes_done++;
        end
    end

    initial begin
        for (int k = 0; k < 20000 && lanes_done < 2; k++) @(posedge clk);
        if (lanes_done < 2) begin
            checks++;
            failures++;
            $display("FAIL run_timeout: lanes_done=%0d required 2", lanes_done);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
